// File: rtl/spi_master_cfg.sv
// spi_master_cfg: SPI master with configurable width, divider, CPOL/CPHA and bit order.
// Full duplex; ready/new_data start handshake and a one-cycle done pulse.
module spi_master_cfg #(
  parameter int DATA_WIDTH = 12,
  parameter int CLK_DIV    = 10,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_data,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  miso,
  output logic                  ready,
  output logic                  cs,
  output logic                  sclk,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  done
);
  localparam int DW_DIV = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int TW     = $clog2(2 * DATA_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
  state_t                state_q, state_d;
  logic [DW_DIV-1:0]     div_q, div_d;
  logic [TW-1:0]         tog_q, tog_d, tog_n;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic                  sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic                  tick, last;
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shifted(input logic [DATA_WIDTH-1:0] w);
    return LSB_FIRST ? w >> 1 : w << 1;
  endfunction
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tog_d   = tog_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
    tick    = div_q == DW_DIV'(CLK_DIV - 1);
    tog_n   = tog_q + 1'b1;
    last    = tog_n == TW'(2 * DATA_WIDTH);
    if (state_q != IDLE) div_d = tick ? '0 : div_q + 1'b1;
    if (state_q == IDLE) begin
      if (new_data) begin
        state_d = SETUP;
        div_d   = '0;
        tog_d   = '0;
        tx_d    = CPHA ? din : shifted(din);
        mosi_d  = CPHA ? 1'b0 : first_bit(din);
      end
    end else if ((state_q == SETUP || state_q == XFER) && tick) begin
      // odd toggle count = leading edge; sampling happens on the edge selected by CPHA
      sclk_d  = ~sclk_q;
      tog_d   = tog_n;
      state_d = last ? HOLD : XFER;
      if (tog_n[0] != CPHA)
        rx_d = LSB_FIRST ? {miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso};
      else if (!last) begin
        mosi_d = first_bit(tx_q);
        tx_d   = shifted(tx_q);
      end
    end else if (state_q == HOLD && tick) begin
      state_d = IDLE;
      mosi_d  = 1'b0;
      dout_d  = rx_q;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      tog_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sclk_q  <= CPOL;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end
  assign ready = state_q == IDLE;
  assign cs    = state_q == IDLE;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign dout  = dout_q;
  assign done  = done_q;
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised SPI master that generalises the existing 12-bit, mode-0, transmit-only master. It adds configurable word width, clock divider, all four CPOL/CPHA modes, bit order and full-duplex MISO capture. A ready/new_data handshake is used, and completion is flagged by a done pulse. It sits between a host-side register or stimulus interface and one SPI slave.

Parameters:
DATA_WIDTH, 12, bits per frame; legal range 2..32.
CLK_DIV, 10, clk cycles per SCLK half-period; legal minimum 1.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
LSB_FIRST, 1, 1 = bit 0 first on MOSI and MISO; 0 = MSB first.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset
new_data  in  1  start request; accepted only when ready=1
din  in  DATA_WIDTH  transmit word; sampled on the accept edge only
miso  in  1  serial data from slave; already synchronous to clk
ready  out  1  high when idle and able to accept new_data
cs  out  1  active-low chip select
sclk  out  1  SPI clock
mosi  out  1  serial data to slave
dout  out  DATA_WIDTH  last received word; held until the next done
done  out  1  one-clk pulse when a frame completes

Behaviour:
- Reset (rst=0, asynchronous, regardless of state): state=IDLE, cs=1, sclk=CPOL, mosi=0, ready=1, done=0, dout=0, all counters 0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is issued and dout is cleared.
- States: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE: cs=1, sclk=CPOL, mosi=0, ready=1.
  - Accept edge = rising clk with new_data=1 and ready=1.
  - On the accept edge: latch din into the tx shift register, ready<=0, cs<=0, go to SETUP.
  - If CPHA=0, mosi is also driven with the first bit on this edge; if CPHA=1, mosi stays 0.
- SETUP: lasts CLK_DIV clk cycles. At the end of SETUP, sclk makes its first toggle and the state moves to XFER.
- XFER: sclk toggles every CLK_DIV cycles, for 2*DATA_WIDTH toggles total counting the one leaving SETUP.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - CPHA=0: sample miso on each leading edge; drive the next bit on each trailing edge except the last.
  - CPHA=1: drive the next bit on each leading edge; sample miso on each trailing edge.
  - After the final toggle, sclk=CPOL; go to HOLD.
- HOLD: lasts CLK_DIV cycles. On its final edge, all of the following happen in the same edge, then the state returns to IDLE:
  - cs<=1, mosi<=0, ready<=1.
  - dout<=rx shift register.
  - done<=1 for exactly one cycle.
- Latency: from the accept edge to the cs-rise/done edge is (2*DATA_WIDTH+1)*CLK_DIV clk cycles. Default parameters give 250 cycles.
- Bit order: LSB_FIRST selects shift direction for both tx and rx. Received bits are assembled so that dout equals the slave's word in the same bit order.
- new_data while ready=0 is ignored and never queued. din changes after the accept edge have no effect.
- Back-to-back: new_data held high through done is accepted on the first edge after ready returns high. cs stays high for at least 1 clk between frames.
- done and ready rising on the same edge is legal and required.
- Dividers: a single half-period counter runs 0..CLK_DIV-1 and is active only outside IDLE. CLK_DIV=1 gives sclk = clk/2 during XFER.

Test Plan:
- Mode 0 loopback (miso tied to mosi), defaults, din=12'hA5C, new_data 1 cycle -> 12 sclk rising edges; dout=12'hA5C; done pulses exactly 1 cycle, 250 clks after the accept edge; cs low 250 clks.
- Mode 3 (CPOL=1, CPHA=1), MSB first, slave model returns 12'h3C1 while din=12'hFFF -> sclk idles high; mosi stable at each rising sclk; dout=12'h3C1.
- DATA_WIDTH=8, CLK_DIV=1, mode 1, loopback din=8'h81 -> sclk period 2 clks; done at 17 clks after accept; dout=8'h81.
- new_data held high continuously, din=12'h001 then 12'h800 -> two frames; new_data pulses during XFER ignored; second accept 1 clk after the first done; cs high exactly 1 clk between frames.
- Reset mid-frame (rst low at clk 100 of frame, din=12'h555) -> cs=1, sclk=CPOL, ready=1, dout=0 immediately (asynchronous); no done; next frame with 12'h0F0 completes correctly.
- Mode 2 (CPOL=1, CPHA=0) check -> sclk stays high in IDLE, SETUP and HOLD; exactly 2*DATA_WIDTH sclk toggles per frame.
